// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin mux arbiter:
// FSM encoding, requester count and the rotating-priority search.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Returns {found, index}: first valid requester after ptr, wrapping, ptr itself last.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                         input logic [1:0] ptr);
    logic [2:0] result;
    logic [1:0] idx;
    result = {1'b0, ptr};
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Four-way WIDTH-bit data selector shared by all requesters.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    unique case (sel)
      2'd0:    dout = din0;
      2'd1:    dout = din1;
      2'd2:    dout = din2;
      default: dout = din3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Merges four valid/ready streams into one registered output through a shared mux4,
// with round-robin arbitration that holds a grant for the whole burst.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  state_t           state_reg, state_next;
  logic [1:0]       rr_ptr_reg, rr_ptr_next;
  logic [1:0]       lock_src_reg, lock_src_next;
  logic [1:0]       sel;
  logic [2:0]       arb_pick;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] mux_dout;

  mux4 #(.WIDTH(WIDTH)) u_mux4 (
    .din0 (din0),
    .din1 (din1),
    .din2 (din2),
    .din3 (din3),
    .sel  (sel),
    .dout (mux_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= 2'd3;
      lock_src_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      lock_src_reg <= lock_src_next;
    end
  end

  // Pointer moves only when a burst completes; a lock freezes arbitration.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    lock_src_next = lock_src_reg;
    if (accept) begin
      if (state_reg == ST_IDLE) begin
        if (in_last[sel]) begin
          rr_ptr_next = sel;
        end else begin
          state_next    = ST_LOCKED;
          lock_src_next = sel;
        end
      end else if (in_last[sel]) begin
        state_next  = ST_IDLE;
        rr_ptr_next = lock_src_reg;
      end
    end
  end

  always_comb begin
    arb_pick  = rr_pick(in_valid, rr_ptr_reg);
    sel       = (state_reg == ST_LOCKED) ? lock_src_reg : arb_pick[1:0];
    slot_free = ~out_valid | out_ready;
  end

  // While locked the owner sees ready even when idle, so a gap costs no re-arbitration.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign in_ready[gi] = ~rst & slot_free & (sel == 2'(gi)) &
                          ((state_reg == ST_LOCKED) | in_valid[gi]);
  end

  assign accept = |(in_valid & in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 2'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_dout;
      out_last  <= in_last[sel];
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: per-cycle comparison against a burst-level reference model,
// plus hand-computed transfer sequences for each directed scenario.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_valid = 4'h0;
  logic [3:0] in_last = 4'h0;
  logic [7:0] din0 = 8'd16, din1 = 8'd32, din2 = 8'd64, din3 = 8'd128;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_src;
  logic       out_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  logic [1:0] log_src[$];
  logic [7:0] log_data[$];

  // Model: current burst owner (-1 = none), last burst winner, and the expected output register.
  int         m_owner;
  int         m_winner;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] m_src;

  mux4_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] din_of(input int i);
    case (i)
      0:       return din0;
      1:       return din1;
      2:       return din2;
      default: return din3;
    endcase
  endfunction

  // Who transfers this cycle: the burst owner if it is valid, else first valid after the last winner.
  function automatic int grant_of(input logic [3:0] v, input int owner, input int winner, input bit sf);
    if (!sf) return -1;
    if (owner >= 0) return v[owner] ? owner : -1;
    for (int k = 1; k <= 4; k++) begin
      if (v[(winner + k) % 4]) return (winner + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] ready_of(input logic [3:0] v, input int owner, input int winner, input bit sf);
    int g;
    if (!sf) return 4'h0;
    if (owner >= 0) return 4'h1 << owner;
    g = grant_of(v, owner, winner, sf);
    return (g >= 0) ? (4'h1 << g) : 4'h0;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    int g;
    if (rst) begin
      m_owner  <= -1;
      m_winner <= 3;
      m_valid  <= 1'b0;
      m_data   <= 8'd0;
      m_last   <= 1'b0;
      m_src    <= 2'd0;
    end else begin
      g = grant_of(in_valid, m_owner, m_winner, !m_valid || out_ready);
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= din_of(g);
        m_last  <= in_last[g];
        m_src   <= 2'(g);
        if (in_last[g]) begin
          m_owner  <= -1;
          m_winner <= g;
        end else begin
          m_owner <= g;
        end
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && !rst) begin
      check("in_ready", 32'(in_ready), 32'(ready_of(in_valid, m_owner, m_winner, !m_valid || out_ready)));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_last", 32'(out_last), 32'(m_last));
      check("out_src", 32'(out_src), 32'(m_src));
      if (out_valid && out_ready) begin
        log_src.push_back(out_src);
        log_data.push_back(out_data);
      end
    end
  end

  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
    set_in(v, l, r);
    tick();
  endtask

  // Asynchronous reset landing mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    log_src.delete();
    log_data.delete();
    tick();
  endtask

  task automatic check_log(input string name, input int n, input logic [15:0] srcs);
    check({name, "_count"}, 32'(log_src.size()), 32'(n));
    for (int i = 0; i < n && i < log_src.size(); i++) begin
      check({name, "_src"}, 32'(log_src[i]), 32'(srcs[2*i +: 2]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_d [6];
    exp_d = '{8'd16, 8'd32, 8'd64, 8'd128, 8'd16, 8'd32};

    tick();
    do_reset();
    check_en = 1'b1;

    // 1. Reset in the middle of a burst from requester 1.
    drive(4'b0010, 4'b0000, 1'b1);
    drive(4'b0010, 4'b0000, 1'b1);
    set_in(4'b0000, 4'b0000, 1'b1);
    do_reset();
    drive(4'b0011, 4'b0011, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);
    check_log("t1_after_reset", 1, 16'h0000);

    // 2. All requesters with single beats: strict rotation, one beat per cycle.
    do_reset();
    for (int i = 0; i < 6; i++) drive(4'hF, 4'hF, 1'b1);
    drive(4'h0, 4'h0, 1'b1);
    drive(4'h0, 4'h0, 1'b1);
    check_log("t2_rotate", 6, {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
    for (int i = 0; i < 6 && i < log_data.size(); i++) check("t2_data", 32'(log_data[i]), 32'(exp_d[i]));

    // 3. Requester 1 holds a three-beat burst while 0 and 2 wait.
    do_reset();
    drive(4'b0001, 4'b1111, 1'b1);
    drive(4'b0111, 4'b1101, 1'b1);
    drive(4'b0111, 4'b1101, 1'b1);
    drive(4'b0111, 4'b1111, 1'b1);
    drive(4'b0111, 4'b1111, 1'b1);
    drive(4'b0111, 4'b1111, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);
    check_log("t3_burst", 6, {2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0});

    // 4. Four cycles of backpressure with a full output register.
    do_reset();
    drive(4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_in(4'hF, 4'hF, 1'b0);
      #1;
      check("t4_hold_data", 32'(out_data), 32'd16);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) drive(4'hF, 4'hF, 1'b1);
    drive(4'h0, 4'h0, 1'b1);
    drive(4'h0, 4'h0, 1'b1);
    check_log("t4_bp", 4, {8'h00, 2'd3, 2'd2, 2'd1, 2'd0});

    // 5. Locked requester 3 goes quiet; requester 0 must not sneak in.
    do_reset();
    drive(4'b1000, 4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      set_in(4'b0001, 4'b0000, 1'b1);
      #1;
      check("t5_gap_ready", 32'(in_ready), 32'h8);
      tick();
    end
    drive(4'b1001, 4'b1000, 1'b1);
    drive(4'b0001, 4'b0001, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);
    check_log("t5_gap", 3, {10'h000, 2'd0, 2'd3, 2'd3});

    // 6. Only requester 2 active.
    do_reset();
    for (int i = 0; i < 5; i++) drive(4'b0100, 4'b0100, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);
    check_log("t6_sparse", 5, 16'h02AA);
    for (int i = 0; i < log_data.size(); i++) check("t6_data", 32'(log_data[i]), 32'd64);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
